// File: rtl/fifo.sv
// Single-clock byte FIFO with full/empty/threshold flags and sticky overflow/underflow.
// Optional occupancy port fifo_count is present only when FIFO_COUNT_EN is defined.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int THRESH     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_thresh,
  output logic                  fifo_overflow,
`ifdef FIFO_COUNT_EN
  output logic                  fifo_underflow,
  output logic [ADDR_WIDTH:0]   fifo_count
`else
  output logic                  fifo_underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] THRESH_L = (ADDR_WIDTH+1)'(THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_en, rd_en;

  // Extra pointer bit distinguishes full from empty when the address bits match.
  assign count       = wr_ptr_q - rd_ptr_q;
  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                       (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign fifo_thresh = (count >= THRESH_L);

  assign wr_en = wr && !fifo_full;
  assign rd_en = rd && !fifo_empty;

  // A rejected access in the same cycle as an opposite accepted access still sets its flag.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    data_out_d  = data_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
    if (wr && !wr_en)  overflow_d = 1'b1;
    else if (rd_en)    overflow_d = 1'b0;
    if (rd && !rd_en)  underflow_d = 1'b1;
    else if (wr_en)    underflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
  end

  assign data_out       = data_out_q;
  assign fifo_overflow  = overflow_q;
  assign fifo_underflow = underflow_q;
`ifdef FIFO_COUNT_EN
  assign fifo_count     = count;
`endif

endmodule

// File: tb/tb_fifo.sv
// Randomized and directed bench for fifo against a queue-based reference model.
// Define FIFO_COUNT_EN for both bench and RTL to also check fifo_count.
module tb_fifo;

  logic       clk;
  logic       reset;
  logic       wr;
  logic       rd;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_thresh;
  logic       fifo_overflow;
  logic       fifo_underflow;
`ifdef FIFO_COUNT_EN
  logic [4:0] fifo_count;
`endif

  fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .THRESH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr             (wr),
    .rd             (rd),
    .data_in        (data_in),
    .data_out       (data_out),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_thresh    (fifo_thresh),
    .fifo_overflow  (fifo_overflow),
`ifdef FIFO_COUNT_EN
    .fifo_underflow (fifo_underflow),
    .fifo_count     (fifo_count)
`else
    .fifo_underflow (fifo_underflow)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Reference model: contents as a queue, flags from plain occupancy rules.
  logic [7:0] m_q[$];
  logic [7:0] m_dout;
  logic       m_ovf;
  logic       m_unf;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, obs, exp, txn);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic compare_all();
    int sz;
    sz = m_q.size();
    check_val("data_out",  {24'h0, data_out}, {24'h0, m_dout});
    check_val("full",      {31'h0, fifo_full},      {31'h0, (sz == 16)});
    check_val("empty",     {31'h0, fifo_empty},     {31'h0, (sz == 0)});
    check_val("thresh",    {31'h0, fifo_thresh},    {31'h0, (sz >= 8)});
    check_val("overflow",  {31'h0, fifo_overflow},  {31'h0, m_ovf});
    check_val("underflow", {31'h0, fifo_underflow}, {31'h0, m_unf});
`ifdef FIFO_COUNT_EN
    check_val("count",     {27'h0, fifo_count},     sz);
`endif
  endtask

  // Called at a falling edge; drives one cycle, then checks at the next falling edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    logic wa, ra;
    int   sz;
    wr = w; rd = r; data_in = d;
    sz = m_q.size();
    wa = w && (sz < 16);
    ra = r && (sz > 0);
    if (ra) m_dout = m_q.pop_front();
    if (wa) m_q.push_back(d);
    if (w && !wa)  m_ovf = 1'b1;
    else if (ra)   m_ovf = 1'b0;
    if (r && !ra)  m_unf = 1'b1;
    else if (wa)   m_unf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    txn++;
    $display("txn %0d wr=%0b rd=%0b din=%02h dout=%02h occ=%0d", txn, w, r, d, data_out, m_q.size());
    compare_all();
  endtask

  initial begin
    wr = 1'b0; rd = 1'b0; data_in = 8'h00;
    reset = 1'b0;
    model_reset();
    #20;
    compare_all();
    reset = 1'b1;

    // Fill to full, then one overflowing write.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b0, 8'hAA);
    // Drain in order, then one underflowing read.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'h00);

    // Pointer wrap.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00);

    // Simultaneous read/write at 5 entries.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd128);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);

    // Mid-cycle asynchronous reset at 9 entries.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    reset = 1'b1;
    compare_all();

    // Random traffic with phases biased toward filling and draining.
    for (int ph = 0; ph < 6; ph++) begin
      int pw;
      pw = (ph % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 60; i++) begin
        logic w, r;
        w = ($urandom_range(99) < pw);
        r = ($urandom_range(99) < (100 - pw));
        step(w, r, 8'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
